param_universal_shift: RTL and testbench

- Parametrised universal shift register with parallel load, six shift/rotate modes and a counted-burst engine.
- Next generation of the team's loadable shift blocks: load is honoured and has the highest functional priority.
- Used as a generic serialiser/deserialiser and bit-manipulation stage in sequential datapath test circuits.

---
 rtl/param_universal_shift.sv | 129 ++++++++++++
 tb/tb_param_universal_shift.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_universal_shift.sv
// Universal shift register: parallel load, six shift/rotate modes, counted burst engine.
// Optional feature macro: UNIV_SHIFT_PARITY_EN (parity output + parity-insert SHL in mode 110).
module param_universal_shift #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             din,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             sout_l,
   output logic             sout_r,
`ifdef UNIV_SHIFT_PARITY_EN
   output logic             parity,
`endif
   output logic [WIDTH-1:0] q
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [2:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   count_sat;

   function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0] m,
                                                   input logic [WIDTH-1:0] v,
                                                   input logic s);
      case (m)
         3'b001:  apply_mode = {v[WIDTH-2:0], s};
         3'b010:  apply_mode = {s, v[WIDTH-1:1]};
         3'b011:  apply_mode = {v[WIDTH-2:0], v[WIDTH-1]};
         3'b100:  apply_mode = {v[0], v[WIDTH-1:1]};
         3'b101:  apply_mode = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef UNIV_SHIFT_PARITY_EN
         3'b110:  apply_mode = {v[WIDTH-2:0], ^v};
`endif
         default: apply_mode = v;
      endcase
   endfunction

   // Requests beyond the register width would only re-shift; clamp to WIDTH steps.
   assign count_sat = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      q_d     = q_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (load) begin
         q_d     = data;
         state_d = IDLE;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else if (state_q == IDLE) begin
         if (start) begin
            if (count_sat != '0) begin
               mode_d  = mode;
               cnt_d   = count_sat;
               busy_d  = 1'b1;
               state_d = BUSY;
            end else begin
               done_d = 1'b1;
            end
         end else if (en) begin
            q_d = apply_mode(mode, q_q, din);
         end
      end else begin
         q_d   = apply_mode(mode_q, q_q, din);
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         mode_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef UNIV_SHIFT_PARITY_EN
   logic parity_q;

   // Tracking ^q_d every edge keeps parity equal to ^q whether q shifted, loaded or held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= ^q_d;
   end

   assign parity = parity_q;
`endif

   assign q      = q_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];

endmodule

// File: tb/tb_param_universal_shift.sv
// Directed bench for param_universal_shift (WIDTH=8) with an expected-state scoreboard queue.
module tb_param_universal_shift;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] data;
   logic       en;
   logic [2:0] mode;
   logic       din;
   logic       start;
   logic [3:0] count;
   logic       busy, done, sout_l, sout_r;
   logic [7:0] q;
`ifdef UNIV_SHIFT_PARITY_EN
   logic       parity;
`endif

   param_universal_shift #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .data   (data),
      .en     (en),
      .mode   (mode),
      .din    (din),
      .start  (start),
      .count  (count),
      .busy   (busy),
      .done   (done),
      .sout_l (sout_l),
      .sout_r (sout_r),
`ifdef UNIV_SHIFT_PARITY_EN
      .parity (parity),
`endif
      .q      (q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [7:0] eq, input logic eb, input logic ed);
      exp_t e;
      e.q = eq; e.busy = eb; e.done = ed;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".q"},    q,           e.q);
         check({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
         check({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; data = v;
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; data = '0; en = 1'b0; mode = '0;
      din = 1'b0; start = 1'b0; count = '0;
      #12;
      push(8'h00, 1'b0, 1'b0);
      pop_check("reset");
      rst = 1'b0;
      tick();

      // Load beats a simultaneous en step, then four SHL steps with din=1.
      load = 1'b1; data = 8'b1010_0101; en = 1'b1; mode = 3'b001; din = 1'b1;
      tick();
      load = 1'b0;
      push(8'hA5, 1'b0, 1'b0);
      pop_check("load_prio");
      push(8'h4B, 0, 0); push(8'h97, 0, 0); push(8'h2F, 0, 0); push(8'h5F, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         pop_check("shl_en");
      end
      en = 1'b0;

      // Rotates, arithmetic shift, hold mode.
      do_load(8'h81);
      check("sout_l_81", {7'd0, sout_l}, 8'd1);
      check("sout_r_81", {7'd0, sout_r}, 8'd1);
      en = 1'b1; mode = 3'b011;
      push(8'h03, 0, 0); tick(); pop_check("rol");
      check("sout_l_03", {7'd0, sout_l}, 8'd0);
      mode = 3'b100;
      push(8'h81, 0, 0); tick(); pop_check("ror");
      mode = 3'b101;
      push(8'hC0, 0, 0); tick(); pop_check("asr");
      mode = 3'b111;
      push(8'hC0, 0, 0); tick(); pop_check("hold111");
      en = 1'b0;

      // Burst of 4 SHR din=0; start/en/mode changes during BUSY are ignored.
      do_load(8'hF0);
      start = 1'b1; count = 4'd4; mode = 3'b010; din = 1'b0;
      push(8'hF0, 1, 0); push(8'h78, 1, 0); push(8'h3C, 1, 0);
      push(8'h1E, 1, 0); push(8'h0F, 0, 1); push(8'h0F, 0, 0);
      tick(); pop_check("burst_start");
      start = 1'b0;
      tick(); pop_check("burst_s1");
      start = 1'b1; count = 4'd2; mode = 3'b001; en = 1'b1;
      tick(); pop_check("burst_s2");
      start = 1'b0; en = 1'b0;
      tick(); pop_check("burst_s3");
      tick(); pop_check("burst_s4");
      tick(); pop_check("burst_after");

      // count=0: no shift, done pulse only.
      start = 1'b1; count = 4'd0; mode = 3'b001; din = 1'b1;
      push(8'h0F, 0, 1); push(8'h0F, 0, 0);
      tick(); pop_check("cnt0");
      start = 1'b0;
      tick(); pop_check("cnt0_after");

      // count=9 saturates to 8 ROL steps: 01 comes back round to 01.
      do_load(8'h01);
      start = 1'b1; count = 4'd9; mode = 3'b011;
      push(8'h01, 1, 0);
      for (int k = 1; k < 8; k++) push(8'h01 << k, 1, 0);
      push(8'h01, 0, 1); push(8'h01, 0, 0);
      tick(); pop_check("sat_start");
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         pop_check("sat_step");
      end

      // Load during BUSY aborts the burst with no done pulse.
      do_load(8'h3C);
      start = 1'b1; count = 4'd5; mode = 3'b001; din = 1'b1;
      push(8'h3C, 1, 0); push(8'h79, 1, 0); push(8'hC3, 0, 0); push(8'hC3, 0, 0);
      tick(); pop_check("abort_start");
      start = 1'b0;
      tick(); pop_check("abort_s1");
      load = 1'b1; data = 8'hC3;
      tick(); pop_check("abort_load");
      load = 1'b0;
      tick(); pop_check("abort_after");

      // Async reset mid-burst takes effect without a clock edge.
      do_load(8'hA5);
      start = 1'b1; count = 4'd5; mode = 3'b001; din = 1'b0;
      push(8'hA5, 1, 0); push(8'h4A, 1, 0); push(8'h94, 1, 0); push(8'h00, 0, 0);
      tick(); pop_check("rstb_start");
      start = 1'b0;
      tick(); pop_check("rstb_s1");
      tick(); pop_check("rstb_s2");
      rst = 1'b1;
      #1;
      pop_check("rst_async");
      #2;
      rst = 1'b0;
      tick();

`ifdef UNIV_SHIFT_PARITY_EN
      do_load(8'h07);
      check("parity_07", {7'd0, parity}, 8'd1);
      en = 1'b1; mode = 3'b110;
      push(8'h0F, 0, 0); tick(); pop_check("par_insert");
      check("parity_0F", {7'd0, parity}, 8'd0);
      en = 1'b0;
`endif

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
